// File: rtl/ram_pkg.sv
// Shared constants and helpers for the pipelined RAM family.
package ram_pkg;

    localparam int MAX_READ_LATENCY = 4;
    localparam int MAX_WIDTH        = 1024;
    localparam int MAX_BYTES        = MAX_WIDTH / 8;

    // Sized for the widest supported word; callers cast their WIDTH-bit values in and out.
    function automatic logic [MAX_WIDTH-1:0] byteMerge(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0] mask
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

    function automatic bit paramsOk(
        input int width,
        input int addr_width,
        input int depth,
        input int read_latency
    );
        return (width > 0) && (width % 8 == 0) && (width <= MAX_WIDTH) &&
               (depth >= 1) && (longint'(depth) <= (longint'(1) << addr_width)) &&
               (read_latency >= 1) && (read_latency <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/ram_read_pipe.sv
// Delay line for read results: each stage carries a valid bit and a word that only
// advances alongside its valid bit, so the output word holds between results.
module ram_read_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             clk_i,
    input  logic             res_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign valid_o = valid_q[STAGES-1];
    assign data_o  = data_q[STAGES-1];

endmodule

// File: rtl/pipelined_ram.sv
// Simple-dual-port synchronous RAM with byte enables, configurable read latency,
// selectable same-address collision behaviour and a read-valid strobe.
module pipelined_ram
    import ram_pkg::*;
#(
    parameter int    WIDTH        = 32,
    parameter int    ADDR_WIDTH   = 10,
    parameter int    DEPTH        = 1 << ADDR_WIDTH,
    parameter int    READ_LATENCY = 1,
    parameter bit    WRITE_FIRST  = 1'b1,
    parameter string TAG          = "RAM",
    localparam int   BYTES        = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [BYTES-1:0]      byteEn,
    input  logic [WIDTH-1:0]      dataIn,
    output logic [WIDTH-1:0]      dataOut,
    output logic                  dataValid,
    output logic                  rangeErr
);

    if (!paramsOk(WIDTH, ADDR_WIDTH, DEPTH, READ_LATENCY)) begin : gen_param_check
        $error("pipelined_ram: illegal WIDTH/ADDR_WIDTH/DEPTH/READ_LATENCY combination");
    end

    localparam logic [ADDR_WIDTH:0] DepthLimit = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             rd_in_range;
    logic             wr_in_range;
    logic             wr_en;
    logic             collision;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] merged_word;
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             range_err_q;

    assign rd_in_range = {1'b0, readAddr} < DepthLimit;
    assign wr_in_range = {1'b0, writeAddr} < DepthLimit;
    assign wr_en       = we & ~res & wr_in_range;
    assign collision   = wr_en & rd_in_range & (readAddr == writeAddr);

    assign rd_word     = mem_q[readAddr];
    assign merged_word = WIDTH'(byteMerge(MAX_WIDTH'(rd_word), MAX_WIDTH'(dataIn),
                                          MAX_BYTES'(byteEn)));

    // Out-of-range reads still produce a (zero) result so the valid strobe stays regular.
    always_comb begin
        rd_data_d = '0;
        if (rd_in_range) begin
            rd_data_d = (collision && WRITE_FIRST) ? merged_word : rd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (byteEn[i]) begin
                    mem_q[writeAddr][8*i +: 8] <= dataIn[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            range_err_q <= 1'b0;
        end else begin
            rd_valid_q <= re;
            if (re) begin
                rd_data_q <= rd_data_d;
            end
            range_err_q <= (re & ~rd_in_range) | (we & ~wr_in_range);
        end
    end

    if (READ_LATENCY == 1) begin : gen_direct
        assign dataOut   = rd_data_q;
        assign dataValid = rd_valid_q;
    end else begin : gen_pipe
        ram_read_pipe #(
            .WIDTH  (WIDTH),
            .STAGES (READ_LATENCY - 1)
        ) u_read_pipe (
            .clk_i   (clk),
            .res_i   (res),
            .valid_i (rd_valid_q),
            .data_i  (rd_data_q),
            .valid_o (dataValid),
            .data_o  (dataOut)
        );
    end

    assign rangeErr = range_err_q;

`ifdef DEBUG_DISPLAY
    always @(posedge clk) begin
        if (wr_en) begin
            $display("[%s] write addr=%0h data=%h byteEn=%b", TAG, writeAddr, dataIn, byteEn);
        end
        if (re && !res) begin
            $display("[%s] read addr=%0h", TAG, readAddr);
        end
    end
`endif

endmodule
